md_unit: RTL and testbench

MD_UNIT -- requirements
Module: md_unit

---
 rtl/md_unit_pkg.sv | 40 ++++
 rtl/md_unit_if.sv | 28 ++
 rtl/md_unit.sv | 134 +++++++++++++
 tb/tb_md_unit.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/md_unit_pkg.sv
// Shared constants for the multiply/divide unit.
// Holds the operation codes, the FSM state encoding and the op-class helpers
// used by both the datapath and anything issuing to it.
package md_unit_pkg;

  typedef enum logic [3:0] {
    OpNop   = 4'd0,
    OpMult  = 4'd1,
    OpMultu = 4'd2,
    OpMadd  = 4'd3,
    OpMaddu = 4'd4,
    OpMsub  = 4'd5,
    OpMsubu = 4'd6,
    OpDiv   = 4'd7,
    OpDivu  = 4'd8,
    OpMthi  = 4'd9,
    OpMtlo  = 4'd10,
    OpMfhi  = 4'd11,
    OpMflo  = 4'd12
  } op_e;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StBusy = 1'b1
  } state_e;

  function automatic logic is_mult(op_e op);
    return op inside {OpMult, OpMultu, OpMadd, OpMaddu, OpMsub, OpMsubu};
  endfunction

  function automatic logic is_div(op_e op);
    return op inside {OpDiv, OpDivu};
  endfunction

  // Multi-cycle ops that occupy the unit and stall the pipeline.
  function automatic logic is_md(op_e op);
    return is_mult(op) | is_div(op);
  endfunction

endpackage

// File: rtl/md_unit_if.sv
// Issue/result bundle between the pipeline and md_unit.
//   start, op, rs, rt, cancel : issue side, driven by the pipeline (master)
//   busy, hi, lo, rd_data     : status/results, driven by md_unit (slave)
interface md_unit_if
  import md_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  op_e              op;
  logic [WIDTH-1:0] rs;
  logic [WIDTH-1:0] rt;
  logic             cancel;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] rd_data;

  modport master (
    output start, op, rs, rt, cancel,
    input  busy, hi, lo, rd_data
  );

  modport slave (
    input  start, op, rs, rt, cancel,
    output busy, hi, lo, rd_data
  );
endinterface

// File: rtl/md_unit.sv
// MIPS-style HI/LO multiply/divide unit.
// The full result is computed at issue into a pending register and committed to
// HI/LO after a fixed latency (MULT_CYCLES or DIV_CYCLES). cancel aborts an
// in-flight op; divide by zero occupies the unit but commits nothing.
// Ports:
//   clk   : clock, all state on rising edge
//   reset : asynchronous active-low reset
//   bus   : md_unit_if slave (start/op/rs/rt/cancel in; busy/hi/lo/rd_data out)
module md_unit
  import md_unit_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  md_unit_if.slave    bus
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [2*WIDTH-1:0] pend_q, pend_d;
  logic               pend_vld_q, pend_vld_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  // Datapath: every candidate result for the op presented this cycle.
  logic [2*WIDTH-1:0] rs_sx, rt_sx, rs_zx, rt_zx;
  logic [2*WIDTH-1:0] prod_s, prod_u, hilo, result;
  logic [WIDTH-1:0]   div_rt, quo_s, rem_s, quo_u, rem_u;

  assign rs_sx  = {{WIDTH{bus.rs[WIDTH-1]}}, bus.rs};
  assign rt_sx  = {{WIDTH{bus.rt[WIDTH-1]}}, bus.rt};
  assign rs_zx  = {{WIDTH{1'b0}}, bus.rs};
  assign rt_zx  = {{WIDTH{1'b0}}, bus.rt};
  // Low 2*WIDTH bits of the sign-extended product equal the signed product.
  assign prod_s = rs_sx * rt_sx;
  assign prod_u = rs_zx * rt_zx;
  assign hilo   = {hi_q, lo_q};
  // Keep the divider X-free on rt==0; the result is dropped in that case.
  assign div_rt = (bus.rt == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : bus.rt;
  assign quo_s  = WIDTH'($signed(bus.rs) / $signed(div_rt));
  assign rem_s  = WIDTH'($signed(bus.rs) % $signed(div_rt));
  assign quo_u  = bus.rs / div_rt;
  assign rem_u  = bus.rs % div_rt;

  always_comb begin
    result = '0;
    unique case (bus.op)
      OpMult:  result = prod_s;
      OpMultu: result = prod_u;
      OpMadd:  result = hilo + prod_s;
      OpMaddu: result = hilo + prod_u;
      OpMsub:  result = hilo - prod_s;
      OpMsubu: result = hilo - prod_u;
      OpDiv:   result = {rem_s, quo_s};
      OpDivu:  result = {rem_u, quo_u};
      default: result = '0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start && !bus.cancel) begin
          if (is_md(bus.op)) begin
            state_d    = StBusy;
            cnt_d      = is_mult(bus.op) ? CntW'(MULT_CYCLES - 1) : CntW'(DIV_CYCLES - 1);
            pend_d     = result;
            pend_vld_d = !(is_div(bus.op) && (bus.rt == '0));
          end else if (bus.op == OpMthi) begin
            hi_d = bus.rs;
          end else if (bus.op == OpMtlo) begin
            lo_d = bus.rs;
          end
        end
      end
      StBusy: begin
        // start is ignored here; only cancel or the countdown move the FSM.
        if (bus.cancel) begin
          state_d    = StIdle;
          cnt_d      = '0;
          pend_d     = '0;
          pend_vld_d = 1'b0;
        end else if (cnt_q == '0) begin
          state_d    = StIdle;
          pend_vld_d = 1'b0;
          if (pend_vld_q) begin
            hi_d = pend_q[2*WIDTH-1:WIDTH];
            lo_d = pend_q[WIDTH-1:0];
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  assign bus.busy    = (state_q == StBusy) | (bus.start & is_md(bus.op));
  assign bus.hi      = hi_q;
  assign bus.lo      = lo_q;
  assign bus.rd_data = (bus.op == OpMfhi) ? hi_q :
                       (bus.op == OpMflo) ? lo_q : '0;

endmodule

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit with default parameters.
module tb_md_unit;
  import md_unit_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  md_unit_if #(.WIDTH(32)) bus ();

  md_unit #(
    .WIDTH      (32),
    .MULT_CYCLES(5),
    .DIV_CYCLES (10)
  ) dut (
    .clk  (clk),
    .reset(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.start = 1'b0;
    bus.op    = OpNop;
    bus.rs    = '0;
    bus.rt    = '0;
  endtask

  // Issue one multi-cycle op and follow it until busy drops. Counts busy
  // cycles including the issue cycle, checks HI/LO hold while busy, then the
  // committed HI/LO. With inj set, drives stray starts mid-flight.
  task automatic run_md(input string tag, input op_e o, input logic [31:0] a,
                        input logic [31:0] b, input bit inj, input int exp_n,
                        input logic [63:0] exp_hilo);
    logic [63:0] hilo0;
    int          n;
    bit          early;
    hilo0     = {bus.hi, bus.lo};
    n         = 0;
    early     = 1'b0;
    bus.start = 1'b1;
    bus.op    = o;
    bus.rs    = a;
    bus.rt    = b;
    #1;
    while (bus.busy && n < 40) begin
      n++;
      @(posedge clk);
      #1;
      idle_inputs();
      if (inj && n == 3) begin
        bus.start = 1'b1;
        bus.op    = OpMthi;
        bus.rs    = 32'h1234_5678;
      end
      if (inj && n == 4) begin
        bus.start = 1'b1;
        bus.op    = OpMult;
        bus.rs    = 32'd2;
        bus.rt    = 32'd2;
      end
      #1;
      if (bus.busy && ({bus.hi, bus.lo} !== hilo0)) early = 1'b1;
    end
    check_eq({tag, "_busy_cycles"}, 64'(n), 64'(exp_n));
    check_eq({tag, "_hold"}, {63'd0, early}, 64'd0);
    check_eq({tag, "_hilo"}, {bus.hi, bus.lo}, exp_hilo);
  endtask

  task automatic single(input op_e o, input logic [31:0] a);
    bus.start = 1'b1;
    bus.op    = o;
    bus.rs    = a;
    #1;
    check_eq("mtx_busy", {63'd0, bus.busy}, 64'd0);
    tick();
    idle_inputs();
    #1;
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    rst_n      = 1'b0;
    bus.cancel = 1'b0;
    idle_inputs();
    bus.op = OpMflo;
    #12;
    check_eq("rst_busy", {63'd0, bus.busy}, 64'd0);
    check_eq("rst_hilo", {bus.hi, bus.lo}, 64'd0);
    check_eq("rst_rd", {32'd0, bus.rd_data}, 64'd0);
    rst_n = 1'b1;
    tick();
    check_eq("post_rst_busy", {63'd0, bus.busy}, 64'd0);
    check_eq("post_rst_hilo", {bus.hi, bus.lo}, 64'd0);
    check_eq("post_rst_rd", {32'd0, bus.rd_data}, 64'd0);
    bus.op = OpNop;

    // -3 * 5 = -15
    run_md("mult", OpMult, 32'hFFFF_FFFD, 32'd5, 1'b0, 6, 64'hFFFF_FFFF_FFFF_FFF1);
    bus.op = OpMfhi;
    #1;
    check_eq("mfhi", {32'd0, bus.rd_data}, 64'h0000_0000_FFFF_FFFF);
    bus.op = OpMflo;
    #1;
    check_eq("mflo", {32'd0, bus.rd_data}, 64'h0000_0000_FFFF_FFF1);
    bus.op = OpNop;
    #1;
    check_eq("rd_nop", {32'd0, bus.rd_data}, 64'd0);

    run_md("divu", OpDivu, 32'd17, 32'd5, 1'b0, 11, {32'd2, 32'd3});
    // -7 / 2 = -3 rem -1
    run_md("div", OpDiv, 32'hFFFF_FFF9, 32'd2, 1'b0, 11, 64'hFFFF_FFFF_FFFF_FFFD);

    single(OpMthi, 32'd0);
    single(OpMtlo, 32'hFFFF_FFFF);
    check_eq("mthi_mtlo", {bus.hi, bus.lo}, 64'h0000_0000_FFFF_FFFF);
    run_md("maddu", OpMaddu, 32'd1, 32'd1, 1'b0, 6, 64'h0000_0001_0000_0000);
    run_md("msub", OpMsub, 32'd1, 32'd1, 1'b0, 6, 64'h0000_0000_FFFF_FFFF);
    run_md("multu", OpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 6, 64'hFFFF_FFFE_0000_0001);
    // {hi,lo} + (-1 * 2)
    run_md("madd", OpMadd, 32'hFFFF_FFFF, 32'd2, 1'b0, 6, 64'hFFFF_FFFD_FFFF_FFFF);

    // Cancel two cycles after issue.
    bus.start = 1'b1;
    bus.op    = OpMult;
    bus.rs    = 32'd3;
    bus.rt    = 32'd4;
    tick();
    idle_inputs();
    tick();
    tick();
    bus.cancel = 1'b1;
    #1;
    check_eq("cancel_busy_before", {63'd0, bus.busy}, 64'd1);
    tick();
    bus.cancel = 1'b0;
    #1;
    check_eq("cancel_busy_after", {63'd0, bus.busy}, 64'd0);
    check_eq("cancel_hilo", {bus.hi, bus.lo}, 64'hFFFF_FFFD_FFFF_FFFF);
    repeat (5) tick();
    check_eq("cancel_no_late", {bus.hi, bus.lo}, 64'hFFFF_FFFD_FFFF_FFFF);
    run_md("mult_after_cancel", OpMult, 32'd3, 32'd4, 1'b0, 6, {32'd0, 32'd12});

    // Divide by zero with stray starts while busy: nothing may change.
    run_md("div0", OpDiv, 32'd7, 32'd0, 1'b1, 11, {32'd0, 32'd12});

    // Reset mid-DIVU.
    bus.start = 1'b1;
    bus.op    = OpDivu;
    bus.rs    = 32'd100;
    bus.rt    = 32'd7;
    tick();
    idle_inputs();
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_busy", {63'd0, bus.busy}, 64'd0);
    check_eq("midrst_hilo", {bus.hi, bus.lo}, 64'd0);
    #2;
    rst_n = 1'b1;
    repeat (15) tick();
    check_eq("midrst_no_commit", {bus.hi, bus.lo}, 64'd0);
    check_eq("midrst_idle", {63'd0, bus.busy}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
